// File: rtl/cache_axi_refill_master_if.sv
// AXI4 read-address and read-data channel bundle used by the cache refill master.
interface cache_axi_refill_master_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [31:0]       M_AXI_ARADDR;
  logic [7:0]        M_AXI_ARLEN;
  logic [2:0]        M_AXI_ARSIZE;
  logic [1:0]        M_AXI_ARBURST;
  logic [2:0]        M_AXI_ARPROT;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RLAST;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARPROT,
    output M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARPROT,
    input  M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );
endinterface

// File: rtl/cache_axi_refill_master.sv
// Cache line refill engine: issues one AXI read burst per miss and returns each
// beat tagged with its slot in the line. INCR fetches line-aligned, WRAP fetches
// critical word first. Bad responses, short bursts and long bursts all end in
// refill_done with refill_error set.
module cache_axi_refill_master #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_BEATS = 4,
  parameter bit          WRAP_EN    = 1'b0,
  parameter logic [2:0]  ARPROT_VAL = 3'b100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   refill_addr,
  input  logic                          refill_start,
  output logic                          refill_busy,
  output logic                          refill_done,
  output logic                          refill_error,
  output logic [DATA_W-1:0]             refill_data,
  output logic [$clog2(LINE_BEATS)-1:0] refill_word,
  output logic                          refill_data_valid,
  cache_axi_refill_master_if.master     m_axi
);
  localparam int unsigned       BYTE_W    = $clog2(DATA_W / 8);
  localparam int unsigned       WORD_W    = $clog2(LINE_BEATS);
  localparam logic [31:0]       INCR_MASK = ~((32'd1 << (BYTE_W + WORD_W)) - 32'd1);
  localparam logic [31:0]       WRAP_MASK = ~((32'd1 << BYTE_W) - 32'd1);
  localparam logic [WORD_W-1:0] LAST_CNT  = WORD_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_e;

  state_e              state_q, state_d;
  logic [31:0]         araddr_q, araddr_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [2:0]          arsize_q, arsize_d;
  logic [1:0]          arburst_q, arburst_d;
  logic [2:0]          arprot_q, arprot_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [WORD_W-1:0]   start_slot_q, start_slot_d;
  logic [WORD_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                over_q, over_d;      // line already full, further beats are surplus
  logic                err_q, err_d;        // sticky error for the current transfer
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                dvalid_q, dvalid_d;

  logic r_hs_s, rlast_s, at_last_s, early_s, unused_s;

  assign r_hs_s    = rready_q & m_axi.M_AXI_RVALID;
  assign rlast_s   = m_axi.M_AXI_RLAST;
  assign at_last_s = (beat_cnt_q == LAST_CNT);
  assign early_s   = rlast_s & ~over_q & ~at_last_s;
  assign unused_s  = m_axi.M_AXI_RRESP[0];

  // Next-state and next-output computation for the refill FSM.
  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    arprot_d     = arprot_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    start_slot_d = start_slot_q;
    beat_cnt_d   = beat_cnt_q;
    over_d       = over_q;
    err_d        = err_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    data_d       = data_q;
    word_d       = word_q;
    dvalid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (refill_start) begin
          state_d      = ADDR;
          araddr_d     = refill_addr & (WRAP_EN ? WRAP_MASK : INCR_MASK);
          arlen_d      = 8'(LINE_BEATS - 1);
          arsize_d     = 3'(BYTE_W);
          arburst_d    = WRAP_EN ? 2'b10 : 2'b01;
          arprot_d     = ARPROT_VAL;
          arvalid_d    = 1'b1;
          start_slot_d = WRAP_EN ? refill_addr[BYTE_W +: WORD_W] : '0;
          beat_cnt_d   = '0;
          over_d       = 1'b0;
          err_d        = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (m_axi.M_AXI_ARREADY) begin
          state_d   = DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (r_hs_s) begin
          err_d      = err_q | m_axi.M_AXI_RRESP[1] | over_q | early_s;
          dvalid_d   = ~over_q;
          data_d     = over_q ? data_q : m_axi.M_AXI_RDATA;
          word_d     = over_q ? word_q : start_slot_q + beat_cnt_q;
          beat_cnt_d = at_last_s ? beat_cnt_q : beat_cnt_q + 1'b1;
          over_d     = over_q | (at_last_s & ~rlast_s);
          if (rlast_s) begin
            state_d  = DONE;
            rready_d = 1'b0;
            done_d   = 1'b1;
            error_d  = err_q | m_axi.M_AXI_RRESP[1] | over_q | early_s;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears the transfer and every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      araddr_q     <= 32'd0;
      arlen_q      <= 8'd0;
      arsize_q     <= 3'd0;
      arburst_q    <= 2'd0;
      arprot_q     <= 3'd0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      start_slot_q <= '0;
      beat_cnt_q   <= '0;
      over_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      data_q       <= '0;
      word_q       <= '0;
      dvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      arprot_q     <= arprot_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      start_slot_q <= start_slot_d;
      beat_cnt_q   <= beat_cnt_d;
      over_q       <= over_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      data_q       <= data_d;
      word_q       <= word_d;
      dvalid_q     <= dvalid_d;
    end
  end

  assign refill_busy         = busy_q;
  assign refill_done         = done_q;
  assign refill_error        = error_q;
  assign refill_data         = data_q;
  assign refill_word         = word_q;
  assign refill_data_valid   = dvalid_q;
  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARLEN   = arlen_q;
  assign m_axi.M_AXI_ARSIZE  = arsize_q;
  assign m_axi.M_AXI_ARBURST = arburst_q;
  assign m_axi.M_AXI_ARPROT  = arprot_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_cache_axi_refill_master.sv
// Directed bench: three refill masters (default INCR, WRAP, 64-bit/8-beat), each
// with a small AXI memory slave (word n = 0xA000_0000 + n) and a beat monitor.
module tb_cache_axi_refill_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [2:0]  start_v;
  logic [2:0]  done_v;
  logic        mon_clr;
  int          cyc = 0;
  int          s_cyc, n_assert, n_fail;
  int          ar_delay, err_beat, n_beats;
  logic        r_gap;

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned DW = (g == 2) ? 64 : 32;
    localparam int unsigned LB = (g == 2) ? 8 : 4;
    localparam bit          WR = (g == 1);

    cache_axi_refill_master_if #(.DATA_W(DW)) bus ();
    logic                  busy_s, done_s, err_s, dv_s;
    logic [DW-1:0]         data_s;
    logic [$clog2(LB)-1:0] word_s;

    cache_axi_refill_master #(
      .DATA_W(DW), .LINE_BEATS(LB), .WRAP_EN(WR), .ARPROT_VAL(3'b100)
    ) dut (
      .clk(clk), .rst_n(rst_n), .refill_addr(addr), .refill_start(start_v[g]),
      .refill_busy(busy_s), .refill_done(done_s), .refill_error(err_s),
      .refill_data(data_s), .refill_word(word_s), .refill_data_valid(dv_s),
      .m_axi(bus.master)
    );
    assign done_v[g] = done_s;

    int          ar_cnt, r_beat;
    logic        r_act, gap_ph;
    logic [31:0] r_n, widx;

    // Memory slave: programmable AR delay, optional RVALID gaps, error beat and burst length.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ar_cnt <= 0; r_beat <= 0; r_act <= 1'b0; gap_ph <= 1'b0; r_n <= 32'd0;
      end else begin
        if (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY) ar_cnt <= ar_cnt + 1;
        if (r_act) gap_ph <= r_gap ? !gap_ph : 1'b0;
        if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin
          r_beat <= r_beat + 1;
          if (r_beat == n_beats - 1) r_act <= 1'b0;
        end
        if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
          ar_cnt <= 0; r_act <= 1'b1; r_beat <= 0; gap_ph <= 1'b0;
          r_n <= bus.M_AXI_ARADDR >> $clog2(DW / 8);
        end
      end
    end
    assign widx              = (r_n & ~32'(LB - 1)) | ((r_n + 32'(r_beat)) & 32'(LB - 1));
    assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (ar_cnt >= ar_delay);
    assign bus.M_AXI_RVALID  = r_act && !gap_ph;
    assign bus.M_AXI_RDATA   = DW'(32'hA000_0000 + widx);
    assign bus.M_AXI_RRESP   = (r_beat == err_beat) ? 2'b10 : 2'b00;
    assign bus.M_AXI_RLAST   = (r_beat == n_beats - 1);

    int          sv_cnt, done_cnt;
    logic        done_err;
    logic [63:0] sv_data [16];
    int          sv_words [16];

    // Monitor: records every strobed beat and every completion.
    always @(negedge clk) begin
      if (mon_clr) begin
        sv_cnt <= 0; done_cnt <= 0; done_err <= 1'b0;
      end else begin
        if (dv_s) begin
          sv_data[word_s] <= 64'(data_s);
          sv_words[sv_cnt] <= int'(word_s);
          sv_cnt <= sv_cnt + 1;
        end
        if (done_s) begin
          done_cnt <= done_cnt + 1;
          done_err <= err_s;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic kick(input int g, input logic [31:0] a);
    addr = a;
    start_v = 3'b000;
    start_v[g] = 1'b1;
    s_cyc = cyc;
    step();
    start_v = 3'b000;
  endtask

  task automatic wait_done(input int g, input int lim);
    int n;
    n = 0;
    while (!done_v[g] && n < lim) begin
      step();
      n++;
    end
    chk("done_timeout", 64'(n < lim), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; addr = 32'd0; start_v = 3'b000; mon_clr = 1'b0;
    ar_delay = 0; err_beat = -1; n_beats = 4; r_gap = 1'b0;
    step();
    step();
    chk("rst_ctl", 64'({g_cfg[0].busy_s, g_cfg[0].done_s, g_cfg[0].err_s, g_cfg[0].dv_s,
                        g_cfg[0].bus.M_AXI_ARVALID, g_cfg[0].bus.M_AXI_RREADY}), 64'd0);
    chk("rst_ar", 64'({g_cfg[0].bus.M_AXI_ARLEN, g_cfg[0].bus.M_AXI_ARSIZE,
                       g_cfg[0].bus.M_AXI_ARBURST, g_cfg[0].bus.M_AXI_ARPROT}), 64'd0);
    chk("rst_araddr", 64'(g_cfg[0].bus.M_AXI_ARADDR), 64'd0);
    rst_n = 1'b1;
    step();

    // Default INCR refill at 0x104.
    clr();
    kick(0, 32'h0000_0104);
    chk("t1_araddr", 64'(g_cfg[0].bus.M_AXI_ARADDR), 64'h100);
    chk("t1_ar", 64'({g_cfg[0].bus.M_AXI_ARLEN, g_cfg[0].bus.M_AXI_ARSIZE, g_cfg[0].bus.M_AXI_ARBURST,
                      g_cfg[0].bus.M_AXI_ARPROT, g_cfg[0].bus.M_AXI_ARVALID, g_cfg[0].busy_s}),
        64'({8'd3, 3'd2, 2'd1, 3'd4, 1'b1, 1'b1}));
    wait_done(0, 20);
    chk("t1_latency", 64'(cyc - s_cyc + 1), 64'd7);
    chk("t1_err", 64'(g_cfg[0].err_s), 64'd0);
    chk("t1_cnt", 64'(g_cfg[0].sv_cnt), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_word", 64'(g_cfg[0].sv_words[i]), 64'(i));
      chk("t1_data", g_cfg[0].sv_data[i], 64'(32'hA000_0040 + 32'(i)));
    end
    step();
    chk("t1_idle", 64'({g_cfg[0].busy_s, g_cfg[0].done_s}), 64'd0);

    // WRAP critical-word-first at 0x108.
    clr();
    kick(1, 32'h0000_0108);
    chk("t2_araddr", 64'(g_cfg[1].bus.M_AXI_ARADDR), 64'h108);
    chk("t2_arburst", 64'(g_cfg[1].bus.M_AXI_ARBURST), 64'd2);
    wait_done(1, 20);
    chk("t2_cnt", 64'(g_cfg[1].sv_cnt), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_word", 64'(g_cfg[1].sv_words[i]), 64'((i + 2) % 4));
      chk("t2_data", g_cfg[1].sv_data[i], 64'(32'hA000_0040 + 32'(i)));
    end
    step();

    // 64-bit data, 8-beat line at 0x1F8.
    clr();
    n_beats = 8;
    kick(2, 32'h0000_01F8);
    chk("t3_araddr", 64'(g_cfg[2].bus.M_AXI_ARADDR), 64'h1C0);
    chk("t3_ar", 64'({g_cfg[2].bus.M_AXI_ARLEN, g_cfg[2].bus.M_AXI_ARSIZE, g_cfg[2].bus.M_AXI_ARBURST}),
        64'({8'd7, 3'd3, 2'd1}));
    wait_done(2, 30);
    chk("t3_cnt", 64'(g_cfg[2].sv_cnt), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_word", 64'(g_cfg[2].sv_words[i]), 64'(i));
      chk("t3_data", g_cfg[2].sv_data[i], 64'(32'hA000_0038 + 32'(i)));
    end
    step();

    // SLVERR on beat 1, then a clean refill clears the flag.
    n_beats = 4;
    err_beat = 1;
    clr();
    kick(0, 32'h0000_0104);
    wait_done(0, 20);
    chk("t4_err", 64'(g_cfg[0].err_s), 64'd1);
    chk("t4_cnt", 64'(g_cfg[0].sv_cnt), 64'd4);
    step();
    err_beat = -1;
    clr();
    kick(0, 32'h0000_0200);
    wait_done(0, 20);
    chk("t4_clean_err", 64'(g_cfg[0].err_s), 64'd0);
    chk("t4_clean_data", g_cfg[0].sv_data[0], 64'h0000_0000_A000_0080);
    step();

    // Early RLAST on the second beat.
    n_beats = 2;
    clr();
    kick(0, 32'h0000_0104);
    wait_done(0, 20);
    chk("t5_early_err", 64'(g_cfg[0].err_s), 64'd1);
    chk("t5_early_cnt", 64'(g_cfg[0].sv_cnt), 64'd2);
    step();

    // Five beats for a four-beat line.
    n_beats = 5;
    clr();
    kick(0, 32'h0000_0104);
    wait_done(0, 20);
    chk("t5_late_err", 64'(g_cfg[0].err_s), 64'd1);
    chk("t5_late_cnt", 64'(g_cfg[0].sv_cnt), 64'd4);
    step();

    // Slow ARREADY, ignored re-start, RVALID gaps, reset mid-burst.
    n_beats = 4;
    ar_delay = 5;
    r_gap = 1'b1;
    clr();
    kick(0, 32'h0000_0104);
    addr = 32'h0000_0300;
    start_v[0] = 1'b1;
    step();
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk("t6_ar_hold", 64'({g_cfg[0].bus.M_AXI_ARVALID, g_cfg[0].bus.M_AXI_ARLEN, g_cfg[0].bus.M_AXI_ARADDR}),
          64'({1'b1, 8'd3, 32'h0000_0100}));
      step();
    end
    begin
      int n;
      n = 0;
      while (g_cfg[0].sv_cnt < 1 && n < 30) begin
        step();
        n++;
      end
      chk("t6_beat_timeout", 64'(n < 30), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl", 64'({g_cfg[0].busy_s, g_cfg[0].done_s, g_cfg[0].err_s, g_cfg[0].dv_s,
                           g_cfg[0].bus.M_AXI_ARVALID, g_cfg[0].bus.M_AXI_RREADY}), 64'd0);
    chk("t6_rst_ar", 64'({g_cfg[0].bus.M_AXI_ARLEN, g_cfg[0].bus.M_AXI_ARSIZE,
                          g_cfg[0].bus.M_AXI_ARBURST, g_cfg[0].bus.M_AXI_ARPROT}), 64'd0);
    chk("t6_rst_data", 64'({g_cfg[0].bus.M_AXI_ARADDR, g_cfg[0].data_s}), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    ar_delay = 0;
    r_gap = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t6_no_done", 64'(g_cfg[0].done_cnt), 64'd0);
    chk("t6_idle", 64'(g_cfg[0].busy_s), 64'd0);
    clr();
    kick(0, 32'h0000_0104);
    wait_done(0, 20);
    chk("t6_after_err", 64'(g_cfg[0].err_s), 64'd0);
    chk("t6_after_cnt", 64'(g_cfg[0].sv_cnt), 64'd4);
    chk("t6_after_data", g_cfg[0].sv_data[3], 64'h0000_0000_A000_0043);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
